// File: rtl/tao_xung_burst.sv
// Burst pulse generator: counts rising edges of an asynchronous timebase and
// emits num_pulses pulses of high_ticks/low_ticks ticks, then a done strobe.
module tao_xung_burst #(
    parameter int WW = 8,
    parameter int NW = 8
) (
    input  logic          clki,
    input  logic          rst,
    input  logic          tick_in,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] num_pulses,
    input  logic [WW-1:0] high_ticks,
    input  logic [WW-1:0] low_ticks,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] pulses_left
);

    typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] ph_cnt_q, ph_cnt_d;
    logic [WW-1:0] high_q, high_d;
    logic [WW-1:0] low_q, low_d;
    logic [NW-1:0] left_q, left_d;
    logic          pulse_q, pulse_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic s1_q, s2_q, prev_q;
    logic tick_evt;

    // prev resets to 0 so a timebase already high at release still yields one tick
    always_ff @(posedge clki) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= tick_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign tick_evt = s2_q & ~prev_q;

    always_ff @(posedge clki) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ph_cnt_q <= '0;
            high_q   <= WW'(1);
            low_q    <= WW'(1);
            left_q   <= '0;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_cnt_q <= ph_cnt_d;
            high_q   <= high_d;
            low_q    <= low_d;
            left_q   <= left_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_cnt_d = ph_cnt_q;
        high_d   = high_q;
        low_d    = low_q;
        left_d   = left_q;
        pulse_d  = pulse_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_pulses != '0) begin
                        state_d  = ST_HIGH;
                        ph_cnt_d = '0;
                        high_d   = (high_ticks == '0) ? WW'(1) : high_ticks;
                        low_d    = (low_ticks == '0) ? WW'(1) : low_ticks;
                        left_d   = num_pulses;
                        pulse_d  = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pulse_d = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    ph_cnt_d = '0;
                    left_d   = '0;
                    pulse_d  = 1'b0;
                    busy_d   = 1'b0;
                end else if (tick_evt) begin
                    if (ph_cnt_q == high_q - WW'(1)) begin
                        ph_cnt_d = '0;
                        state_d  = ST_LOW;
                        pulse_d  = 1'b0;
                    end else begin
                        ph_cnt_d = ph_cnt_q + WW'(1);
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    ph_cnt_d = '0;
                    left_d   = '0;
                    pulse_d  = 1'b0;
                    busy_d   = 1'b0;
                end else if (tick_evt) begin
                    if (ph_cnt_q == low_q - WW'(1)) begin
                        ph_cnt_d = '0;
                        left_d   = left_q - NW'(1);
                        if (left_q == NW'(1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            pulse_d = 1'b0;
                        end else begin
                            state_d = ST_HIGH;
                            pulse_d = 1'b1;
                        end
                    end else begin
                        ph_cnt_d = ph_cnt_q + WW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                pulse_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pulse_out   = pulse_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_left = left_q;

endmodule
